// File: rtl/tmds_tx_packer_if.sv
// Symbol source handshake for tmds_tx_packer: one 30-bit beat of three TMDS symbols.
interface tmds_tx_packer_if;
  logic        symbol_valid;
  logic        symbol_ready;
  logic [29:0] symbol_data;

  modport master (output symbol_valid, output symbol_data, input  symbol_ready);
  modport slave  (input  symbol_valid, input  symbol_data, output symbol_ready);
endinterface

// File: rtl/tmds_tx_packer.sv
// TMDS transmit packer: 4-deep beat FIFO, IDLE/FILL/RUN flow control, 4x oversampled GT word.
// Optional macro TX_UNDERFLOW_COUNT_EN adds the saturating underflow_count output.
module tmds_tx_packer #(
  parameter logic [3:0]  LANE_INVERT = 4'b0000,
  parameter int unsigned START_LEVEL = 2
) (
  input  logic             tx_clock,
  input  logic             tx_reset,
  input  logic             enable,
  tmds_tx_packer_if.slave  sym,
  output logic [159:0]     tx_data,
  output logic             running,
  output logic             underflow
`ifdef TX_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]      underflow_count
`endif
);

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned OVS    = 4;
  localparam int unsigned LANE_W = SYM_W * OVS;
  localparam int unsigned BEAT_W = 3 * SYM_W;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned LVL_W  = 3;

  localparam logic [SYM_W-1:0] CTL_SYM = 10'b1101010100;
  localparam logic [SYM_W-1:0] CLK_SYM = 10'b0000011111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state, state_next;
  logic [BEAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push_c, pop_c, underflow_c;
  logic [159:0]      idle_word_c;

  // Bit i of a symbol occupies lane bits [4i+3:4i]; inversion applied after replication.
  function automatic logic [LANE_W-1:0] lane_word(input logic [SYM_W-1:0] s, input logic inv);
    logic [LANE_W-1:0] w;
    w = '0;
    for (int i = 0; i < SYM_W; i++) w[OVS*i +: OVS] = {OVS{s[i]}};
    return w ^ {LANE_W{inv}};
  endfunction

  function automatic logic [159:0] pack_word(input logic [BEAT_W-1:0] beat);
    logic [159:0] w;
    for (int l = 0; l < 3; l++)
      w[LANE_W*l +: LANE_W] = lane_word(beat[SYM_W*l +: SYM_W], LANE_INVERT[l]);
    w[LANE_W*3 +: LANE_W] = lane_word(CLK_SYM, LANE_INVERT[3]);
    return w;
  endfunction

  assign idle_word_c = pack_word({3{CTL_SYM}});

  assign pop_c       = (state == ST_RUN) && enable && (level != '0);
  assign underflow_c = (state == ST_RUN) && enable && (level == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept while running.
  assign sym.symbol_ready = enable && !tx_reset && ((level < LVL_W'(DEPTH)) || pop_c);
  assign push_c      = sym.symbol_valid && sym.symbol_ready;

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_FILL;
        ST_FILL: if (level >= LVL_W'(START_LEVEL)) state_next = ST_RUN;
        ST_RUN:  if (level == '0) state_next = ST_FILL;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge tx_clock) begin
    if (tx_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FIFO pointers and level; dropping enable flushes any buffered beats.
  always_ff @(posedge tx_clock) begin
    if (tx_reset || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge tx_clock) begin
    if (push_c) mem[wr_ptr] <= sym.symbol_data;
  end

  always_ff @(posedge tx_clock) begin
    if (tx_reset) begin
      tx_data   <= idle_word_c;
      running   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tx_data   <= pop_c ? pack_word(mem[rd_ptr]) : idle_word_c;
      running   <= (state_next == ST_RUN);
      underflow <= underflow_c;
    end
  end

`ifdef TX_UNDERFLOW_COUNT_EN
  always_ff @(posedge tx_clock) begin
    if (tx_reset)                                      underflow_count <= '0;
    else if (underflow_c && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tmds_tx_packer.sv
// Directed table-driven bench for tmds_tx_packer: default instance plus START_LEVEL=4 / LANE_INVERT=4'b1000.
module tb_tmds_tx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en_a, en_b;
  logic [159:0] tx_a, tx_b;
  logic         run_a, run_b, uf_a, uf_b;
`ifdef TX_UNDERFLOW_COUNT_EN
  logic [15:0]  cnt_a, cnt_b;
`endif

  tmds_tx_packer_if bus_a ();
  tmds_tx_packer_if bus_b ();

  tmds_tx_packer dut_a (
    .tx_clock(clk), .tx_reset(rst), .enable(en_a), .sym(bus_a.slave),
    .tx_data(tx_a), .running(run_a), .underflow(uf_a)
`ifdef TX_UNDERFLOW_COUNT_EN
    , .underflow_count(cnt_a)
`endif
  );

  tmds_tx_packer #(.LANE_INVERT(4'b1000), .START_LEVEL(4)) dut_b (
    .tx_clock(clk), .tx_reset(rst), .enable(en_b), .sym(bus_b.slave),
    .tx_data(tx_b), .running(run_b), .underflow(uf_b)
`ifdef TX_UNDERFLOW_COUNT_EN
    , .underflow_count(cnt_b)
`endif
  );

  localparam logic [159:0] IDLE_A = {40'h00000FFFFF, 40'hFF0F0F0F00, 40'hFF0F0F0F00, 40'hFF0F0F0F00};
  localparam logic [159:0] IDLE_B = {40'hFFFFF00000, 40'hFF0F0F0F00, 40'hFF0F0F0F00, 40'hFF0F0F0F00};

  localparam logic [29:0] Z   = 30'h0;
  localparam logic [29:0] D1  = {10'h3FF, 10'h2AA, 10'h155};
  localparam logic [29:0] D2  = 30'h12345678;
  localparam logic [29:0] D3  = 30'h0DEADBEE;
  localparam logic [29:0] D4  = 30'h2F0F0F0F;
  localparam logic [29:0] D5  = 30'h30000001;
  localparam logic [29:0] D6  = 30'h000003FF;
  localparam logic [29:0] D7  = 30'h155AA55A;
  localparam logic [29:0] D8  = 30'h0C0FFEE0;
  localparam logic [29:0] D9  = 30'h2AAAAAAA;
  localparam logic [29:0] D10 = 30'h15555555;
  localparam logic [29:0] E1  = 30'h00000001;
  localparam logic [29:0] E2  = 30'h00100200;
  localparam logic [29:0] E3  = 30'h3FF00000;
  localparam logic [29:0] E4  = 30'h000FFC00;
  localparam logic [29:0] E5  = 30'h1C71C71C;
  localparam logic [29:0] E6  = 30'h0369CF3E;

  typedef struct {
    logic        en;
    logic        val;
    logic [29:0] data;
    logic        exp_ready;
    logic        exp_run;
    logic        exp_uf;
    logic        exp_idle;
    logic [29:0] exp_beat;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [1:0] in_bits, input logic [29:0] data,
                              input logic [3:0] exp_bits, input logic [29:0] beat);
    vec_t v;
    v.en = in_bits[1];        v.val = in_bits[0];   v.data = data;
    v.exp_ready = exp_bits[3]; v.exp_run = exp_bits[2];
    v.exp_uf = exp_bits[1];    v.exp_idle = exp_bits[0]; v.exp_beat = beat;
    return v;
  endfunction

  // Reference word: each lane built bit by bit from the symbol it should carry.
  function automatic logic [159:0] model_word(input logic [29:0] beat, input logic [3:0] inv,
                                              input logic idle);
    logic [159:0] w;
    logic [9:0]   s;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      if (l == 3)    s = 10'b0000011111;
      else if (idle) s = 10'b1101010100;
      else           s = beat[10*l +: 10];
      for (int i = 0; i < 10; i++)
        for (int k = 0; k < 4; k++) w[40*l + 4*i + k] = s[i] ^ inv[l];
    end
    return w;
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit sel, input int idx);
    logic [159:0] exp_w;
    string tag;
    tag = $sformatf("%s[%0d]", sel ? "B" : "A", idx);
    @(negedge clk);
    if (!sel) begin
      en_a = v.en; bus_a.symbol_valid = v.val; bus_a.symbol_data = v.data;
    end else begin
      en_b = v.en; bus_b.symbol_valid = v.val; bus_b.symbol_data = v.data;
    end
    #1;
    check({tag, " ready"}, 160'(sel ? bus_b.symbol_ready : bus_a.symbol_ready), 160'(v.exp_ready));
    @(posedge clk);
    #1;
    exp_w = model_word(v.exp_beat, sel ? 4'b1000 : 4'b0000, v.exp_idle);
    check({tag, " tx_data"},   sel ? tx_b : tx_a, exp_w);
    check({tag, " running"},   160'(sel ? run_b : run_a), 160'(v.exp_run));
    check({tag, " underflow"}, 160'(sel ? uf_b : uf_a), 160'(v.exp_uf));
  endtask

  vec_t tab_a[26];
  vec_t tab_b[13];

  initial begin
    tab_a[0]  = mk(2'b10, Z,   4'b1001, Z);
    tab_a[1]  = mk(2'b10, Z,   4'b1001, Z);
    tab_a[2]  = mk(2'b11, D1,  4'b1001, Z);
    tab_a[3]  = mk(2'b11, D2,  4'b1001, Z);
    tab_a[4]  = mk(2'b11, D3,  4'b1101, Z);
    tab_a[5]  = mk(2'b11, D4,  4'b1100, D1);
    tab_a[6]  = mk(2'b10, Z,   4'b1100, D2);
    tab_a[7]  = mk(2'b10, Z,   4'b1100, D3);
    tab_a[8]  = mk(2'b10, Z,   4'b1100, D4);
    tab_a[9]  = mk(2'b10, Z,   4'b1011, Z);
    tab_a[10] = mk(2'b10, Z,   4'b1001, Z);
    tab_a[11] = mk(2'b11, D5,  4'b1001, Z);
    tab_a[12] = mk(2'b11, D6,  4'b1001, Z);
    tab_a[13] = mk(2'b10, Z,   4'b1101, Z);
    tab_a[14] = mk(2'b10, Z,   4'b1100, D5);
    tab_a[15] = mk(2'b10, Z,   4'b1100, D6);
    tab_a[16] = mk(2'b10, Z,   4'b1011, Z);
    tab_a[17] = mk(2'b11, D7,  4'b1001, Z);
    tab_a[18] = mk(2'b11, D8,  4'b1001, Z);
    tab_a[19] = mk(2'b11, D9,  4'b1101, Z);
    tab_a[20] = mk(2'b11, D10, 4'b1100, D7);
    tab_a[21] = mk(2'b01, D10, 4'b0001, Z);
    tab_a[22] = mk(2'b10, Z,   4'b1001, Z);
    tab_a[23] = mk(2'b10, Z,   4'b1001, Z);
    tab_a[24] = mk(2'b10, Z,   4'b1001, Z);
    tab_a[25] = mk(2'b00, Z,   4'b0001, Z);

    tab_b[0]  = mk(2'b11, E1, 4'b1001, Z);
    tab_b[1]  = mk(2'b11, E2, 4'b1001, Z);
    tab_b[2]  = mk(2'b11, E3, 4'b1001, Z);
    tab_b[3]  = mk(2'b11, E4, 4'b1001, Z);
    tab_b[4]  = mk(2'b11, E5, 4'b0101, Z);
    tab_b[5]  = mk(2'b11, E5, 4'b1100, E1);
    tab_b[6]  = mk(2'b11, E6, 4'b1100, E2);
    tab_b[7]  = mk(2'b10, Z,  4'b1100, E3);
    tab_b[8]  = mk(2'b10, Z,  4'b1100, E4);
    tab_b[9]  = mk(2'b10, Z,  4'b1100, E5);
    tab_b[10] = mk(2'b10, Z,  4'b1100, E6);
    tab_b[11] = mk(2'b10, Z,  4'b1011, Z);
    tab_b[12] = mk(2'b00, Z,  4'b0001, Z);

    // Reset with enable and valid asserted: reset must win.
    rst = 1'b1;
    en_a = 1'b1; bus_a.symbol_valid = 1'b1; bus_a.symbol_data = D1;
    en_b = 1'b1; bus_b.symbol_valid = 1'b1; bus_b.symbol_data = E1;
    @(negedge clk);
    #1;
    check("reset ready_a", 160'(bus_a.symbol_ready), 160'(1'b0));
    @(posedge clk);
    #1;
    check("reset tx_a", tx_a, IDLE_A);
    check("reset tx_b", tx_b, IDLE_B);
    check("reset running_a", 160'(run_a), 160'(1'b0));
    check("reset underflow_a", 160'(uf_a), 160'(1'b0));
`ifdef TX_UNDERFLOW_COUNT_EN
    check("reset count_a", 160'(cnt_a), 160'(16'd0));
`endif
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0; bus_a.symbol_valid = 1'b0;
    en_b = 1'b0; bus_b.symbol_valid = 1'b0;

    for (int i = 0; i < 26; i++) begin
      apply(tab_a[i], 1'b0, i);
      if (i == 5) begin
        check("lane0 0x155", 160'(tx_a[39:0]), 160'(40'h0F0F0F0F0F));
        check("lane1 0x2AA", 160'(tx_a[79:40]), 160'(40'hF0F0F0F0F0));
        check("lane2 0x3FF", 160'(tx_a[119:80]), 160'(40'hFFFFFFFFFF));
      end
    end
`ifdef TX_UNDERFLOW_COUNT_EN
    check("count_a two events", 160'(cnt_a), 160'(16'd2));
`endif

    for (int i = 0; i < 13; i++) apply(tab_b[i], 1'b1, i);
    check("B idle word inverted clock lane", tx_b, IDLE_B);
`ifdef TX_UNDERFLOW_COUNT_EN
    check("count_b one event", 160'(cnt_b), 160'(16'd1));
`endif

    // Reach RUN with three beats buffered, then reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_a = 1'b1; bus_a.symbol_valid = 1'b1; bus_a.symbol_data = D2;
    end
    @(posedge clk);
    #1;
    check("pre-reset running_a", 160'(run_a), 160'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset ready_a", 160'(bus_a.symbol_ready), 160'(1'b0));
    @(posedge clk);
    #1;
    check("mid reset tx_a", tx_a, IDLE_A);
    check("mid reset running_a", 160'(run_a), 160'(1'b0));
`ifdef TX_UNDERFLOW_COUNT_EN
    check("mid reset count_a", 160'(cnt_a), 160'(16'd0));
`endif
    @(negedge clk);
    rst = 1'b0;
    bus_a.symbol_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post reset discard run[%0d]", i), 160'(run_a), 160'(1'b0));
      check($sformatf("post reset discard tx[%0d]", i), tx_a, IDLE_A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
